// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
// Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
package dmem_pkg;

  localparam int unsigned DWIDTH = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic              store;
    size_e             size;
    logic              sgn;
    logic [1:0]        lane;
    logic [DWIDTH-1:0] wdata;
  } lsu_req_t;

  // Pull the addressed lane out of a memory word and extend it to full width.
  function automatic logic [DWIDTH-1:0] lane_extract(
    input logic [DWIDTH-1:0] word,
    input size_e             size,
    input logic [1:0]        lane,
    input logic              sgn
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DWIDTH-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    res = sgn ? {{(DWIDTH-8){b[7]}}, b} : {{(DWIDTH-8){1'b0}}, b};
      SZ_H:    res = sgn ? {{(DWIDTH-16){h[15]}}, h} : {{(DWIDTH-16){1'b0}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of a memory word with the store data.
  function automatic logic [DWIDTH-1:0] lane_merge(
    input logic [DWIDTH-1:0] word,
    input logic [DWIDTH-1:0] wdata,
    input size_e             size,
    input logic [1:0]        lane
  );
    logic [DWIDTH-1:0] res;
    res = word;
    case (size)
      SZ_B:    res[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_H:    res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment shared by the load-extract and store-merge paths.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [DWIDTH-1:0] rdata_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  size_e             size_i,
  input  logic [1:0]        lane_i,
  input  logic              sgn_i,
  output logic [DWIDTH-1:0] load_c_o,
  output logic [DWIDTH-1:0] merge_c_o
);

  assign load_c_o  = lane_extract(rdata_i, size_i, lane_i, sgn_i);
  assign merge_c_o = lane_merge(rdata_i, wdata_i, size_i, lane_i);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store requester for a word-wide synchronous data memory.
// Sub-word stores are read-modify-write; bad requests get an error response.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter  int unsigned ALENGTH = 128,
  localparam int unsigned MAW     = $clog2(ALENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [MAW-1:0]    mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d, req_in;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [MAW-1:0]    mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic              acc_err;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] merge_data;

  assign req_in = '{store: req_store, size: size_e'(req_size), sgn: req_signed,
                    lane: req_addr[1:0], wdata: req_wdata};

  // Alignment and range check on the incoming request.
  always_comb begin
    acc_err = 1'b0;
    case (size_e'(req_size))
      SZ_B:    acc_err = 1'b0;
      SZ_H:    acc_err = req_addr[0];
      SZ_W:    acc_err = |req_addr[1:0];
      default: acc_err = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(ALENGTH)) acc_err = 1'b1;
  end

  mem_lane_align u_align (
    .rdata_i   (mem_rdata),
    .wdata_i   (req_q.wdata),
    .size_i    (req_q.size),
    .lane_i    (req_q.lane),
    .sgn_i     (req_q.sgn),
    .load_c_o  (load_data),
    .merge_c_o (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          if (acc_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_store && (size_e'(req_size) == SZ_W)) begin
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr[MAW+1:2];
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = ST_ISSUE;
            mem_addr_d = req_addr[MAW+1:2];
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (req_q.store) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_data;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request and output registers; reset drops mem_we immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed table-driven bench for dmem_lsu with a synchronous word memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];
  int          we_total = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  dmem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; read returns the pre-write word.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_total <= we_total + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
    int n;
    int we0;
    @(negedge clk);
    we0        = we_total;
    req_valid  = 1'b1;
    req_store  = v.store;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    rd  = rsp_rdata;
    er  = rsp_err;
    if (rsp_valid) begin
      @(posedge clk);
      #1;
    end
    wes = we_total - we0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    logic [31:0] held;
    int          n;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h011, 32'h123456A5, 32'h00000000, 1'b0, 3, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h011, 32'h00000000, 32'hFFFFFFA5, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h011, 32'h00000000, 32'h000000A5, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h012, 32'h00000000, 32'hFFFFDEAD, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h012, 32'h00000000, 32'h0000DEAD, 1'b0, 2, 0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h010, 32'h00000000, 32'hFFFFA5EF, 1'b0, 2, 0};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h00000000, 32'h000000DE, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h010, 32'h00000000, 32'hFFFFFFEF, 1'b0, 2, 0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h012, 32'hBEEF0123, 32'h00000000, 1'b0, 3, 1};
    vecs[11] = '{1'b0, 2'd2, 1'b1, 32'h010, 32'h00000000, 32'h0123A5EF, 1'b0, 2, 0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'h80000001, 32'h00000000, 1'b0, 1, 1};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h1FF, 32'h00000000, 32'hFFFFFF80, 1'b0, 2, 0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h013, 32'h00000000, 32'h00000000, 1'b1, 0, 0};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h011, 32'h0000FFFF, 32'h00000000, 1'b1, 0, 0};
    vecs[16] = '{1'b0, 2'd3, 1'b0, 32'h010, 32'h00000000, 32'h00000000, 1'b1, 0, 0};
    vecs[17] = '{1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 32'h00000000, 1'b1, 0, 0};
    vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h00000000, 32'h00000000, 1'b1, 0, 0};
    vecs[19] = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h00000000, 32'h0123A5EF, 1'b0, 2, 0};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i], rd, er, lat, wes);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_we", i), 32'(wes), 32'(vecs[i].exp_we));
    end
    chk("mem4_final", mem[4], 32'h0123A5EF);
    chk("mem127_final", mem[127], 32'h80000001);
    chk("mem0_untouched", mem[0], 32'h0);

    // Mid-idle reset pulse clears every registered output.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("idle_rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("idle_rst_mem_we", 32'(mem_we), 32'h0);
    chk("idle_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("idle_rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rel_req_ready", 32'(req_ready), 32'h1);

    // Back-pressure: response held for 5 cycles.
    @(negedge clk);
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h1FC;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd2);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'h80000001);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'h80000001);
      chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done_valid", 32'(rsp_valid), 32'h0);
    chk("bp_done_ready", 32'(req_ready), 32'h1);

    // Reset while in WRITE: the pending RMW write is lost.
    @(negedge clk);
    wes        = we_total;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h010;
    req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wr_reach_we", 32'(mem_we), 32'h1);
    chk("wr_reach_lat", 32'(n), 32'd2);
    rst = 1'b1;
    #1;
    chk("wr_rst_we", 32'(mem_we), 32'h0);
    chk("wr_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("wr_rst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("wr_rst_mem4", mem[4], 32'h0123A5EF);
    chk("wr_rst_we_cnt", 32'(we_total - wes), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wr_after_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
